pll_reset_seq: RTL

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/pll_reset_seq.sv
// Power-on reset sequencer: waits for a stable PLL lock, then releases the system
// reset aligned to the first rising-phase clock enable of the divided clock.
module pll_reset_seq #(
   parameter int LOCK_CYCLES = 16384,
   parameter int DIV         = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic pll_lock,
   output logic rst_out,
   output logic clk_en,
   output logic clk_en_n,
   output logic lock_lost
);

   localparam int CNT_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
   localparam int PH_W  = $clog2(DIV);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DIV - 1);
   localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(DIV / 2);

   localparam logic [1:0] WAIT_LOCK = 2'd0;
   localparam logic [1:0] STABLE    = 2'd1;
   localparam logic [1:0] RELEASE   = 2'd2;
   localparam logic [1:0] RUN       = 2'd3;

   logic             lock_meta_q, lock_meta_d;
   logic             lock_s_q, lock_s_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic             rst_out_q, rst_out_d;
   logic             clk_en_q, clk_en_d;
   logic             clk_en_n_q, clk_en_n_d;
   logic             lock_lost_q, lock_lost_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
      lock_meta_d = pll_lock;
      lock_s_d    = lock_meta_q;
      state_d     = state_q;
      cnt_d       = '0;
      lock_lost_d = lock_lost_q;

      case (state_q)
         WAIT_LOCK: begin
            if (lock_s_q) state_d = STABLE;
         end
         STABLE: begin
            if (!lock_s_q) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == CNT_LAST) begin
               state_d = RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            if (!lock_s_q) begin
               state_d = WAIT_LOCK;
            end else if (phase_q == PH_LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!lock_s_q) begin
               state_d     = WAIT_LOCK;
               lock_lost_d = 1'b1;
            end
         end
         default: state_d = WAIT_LOCK;
      endcase

      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;

      // Outputs are decoded from next state/phase so they are registered yet line up with state_q.
      rst_out_d  = (state_d != RUN);
      clk_en_d   = (state_d == RUN) && (phase_d == '0);
      clk_en_n_d = (state_d == RUN) && (phase_d == PH_HALF);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         state_q     <= WAIT_LOCK;
         cnt_q       <= '0;
         phase_q     <= '0;
         rst_out_q   <= 1'b1;
         clk_en_q    <= 1'b0;
         clk_en_n_q  <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the pre-edge values, independent of statement order.
         lock_meta_q <= lock_meta_d;
         lock_s_q    <= lock_s_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         rst_out_q   <= rst_out_d;
         clk_en_q    <= clk_en_d;
         clk_en_n_q  <= clk_en_n_d;
         lock_lost_q <= lock_lost_d;
      end
   end

   assign rst_out   = rst_out_q;
   assign clk_en    = clk_en_q;
   assign clk_en_n  = clk_en_n_q;
   assign lock_lost = lock_lost_q;

endmodule
